// File: rtl/mips_multicycle_control_if.sv
// Control/status bundle between the multicycle MIPS controller (master) and its datapath (slave).
interface mips_multicycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             alu_zero;
    logic             mem_ready;

    logic             mem_read;
    logic             mem_write;
    logic             i_or_d;
    logic             ir_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [3:0]       op_alu;
    logic [3:0]       state;
    logic             illegal_op;
    logic             mem_timeout;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, funct, alu_zero, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source, op_alu, state,
               illegal_op, mem_timeout, retired
    );

    modport slave (
        output opcode, funct, alu_zero, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source, op_alu, state,
               illegal_op, mem_timeout, retired
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with memory-wait timeout and retired-instruction counter.
// Optional jal/jr support is enabled by defining MULTICYCLE_JAL_JR_EN.
module mips_multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input logic                        clock,
    input logic                        reset,
    mips_multicycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRExec   = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StIExec   = 4'd10,
        StIWb     = 4'd11
    } state_e;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] op_alu;
        logic       illegal_op;
        logic       mem_timeout;
    } ctl_t;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
`ifdef MULTICYCLE_JAL_JR_EN
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] FnJr    = 6'b001000;
`endif
    // Last wait cycle: a missing mem_ready here is the timeout, a present one still completes.
    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             mem_wait;
    ctl_t             ctl;

    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        retire   = 1'b0;
        mem_wait = 1'b0;
        ctl      = '0;
        unique case (state_q)
            StFetch: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_d      = StDecode;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            StDecode: begin
                ctl.alu_src_b = 2'b11;
                case (bus.opcode)
                    OpLw, OpSw:   state_d = StMemAddr;
                    OpRtype:      state_d = StRExec;
                    OpBeq, OpBne: state_d = StBranch;
                    OpAddi:       state_d = StIExec;
                    OpJ:          state_d = StJump;
`ifdef MULTICYCLE_JAL_JR_EN
                    OpJal:        state_d = StJump;
`endif
                    default: begin
                        ctl.illegal_op = 1'b1;
                        state_d        = StFetch;
                    end
                endcase
            end
            StMemAddr: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                state_d       = (bus.opcode == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
                if (bus.mem_ready) state_d = StMemWb;
                else               mem_wait = 1'b1;
            end
            StMemWb: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                state_d        = StFetch;
                retire         = 1'b1;
            end
            StMemWr: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            StRExec: begin
                ctl.alu_src_a = 1'b1;
                ctl.op_alu    = 4'b0010;
                state_d       = StRWb;
`ifdef MULTICYCLE_JAL_JR_EN
                if (bus.funct == FnJr) begin
                    ctl.pc_write  = 1'b1;
                    ctl.pc_source = 2'b11;
                    state_d       = StFetch;
                    retire        = 1'b1;
                end
`endif
            end
            StRWb: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                state_d       = StFetch;
                retire        = 1'b1;
            end
            StBranch: begin
                ctl.alu_src_a     = 1'b1;
                ctl.op_alu        = 4'b0001;
                ctl.pc_source     = 2'b01;
                // opcode[0] distinguishes bne from beq
                ctl.pc_write_cond = bus.opcode[0] ? ~bus.alu_zero : bus.alu_zero;
                state_d           = StFetch;
                retire            = 1'b1;
            end
            StJump: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = 2'b10;
`ifdef MULTICYCLE_JAL_JR_EN
                ctl.reg_write = (bus.opcode == OpJal);
`endif
                state_d       = StFetch;
                retire        = 1'b1;
            end
            StIExec: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                state_d       = StIWb;
            end
            StIWb: begin
                ctl.reg_write = 1'b1;
                state_d       = StFetch;
                retire        = 1'b1;
            end
            default: state_d = StFetch;
        endcase

        if (mem_wait) begin
            if (wait_q >= WaitLast) begin
                ctl.mem_timeout = 1'b1;
                state_d         = StFetch;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end

        if (reset) ctl = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign bus.mem_read      = ctl.mem_read;
    assign bus.mem_write     = ctl.mem_write;
    assign bus.i_or_d        = ctl.i_or_d;
    assign bus.ir_write      = ctl.ir_write;
    assign bus.pc_write      = ctl.pc_write;
    assign bus.pc_write_cond = ctl.pc_write_cond;
    assign bus.reg_write     = ctl.reg_write;
    assign bus.reg_dst       = ctl.reg_dst;
    assign bus.mem_to_reg    = ctl.mem_to_reg;
    assign bus.alu_src_a     = ctl.alu_src_a;
    assign bus.alu_src_b     = ctl.alu_src_b;
    assign bus.pc_source     = ctl.pc_source;
    assign bus.op_alu        = ctl.op_alu;
    assign bus.illegal_op    = ctl.illegal_op;
    assign bus.mem_timeout   = ctl.mem_timeout;
    assign bus.state         = state_q;
    assign bus.retired       = retired_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Table-driven, scoreboard-checked bench for mips_multicycle_control (MEM_TIMEOUT=4).
module tb_mips_multicycle_control;
    localparam int unsigned MemTimeout = 4;
    localparam int unsigned CntW       = 32;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] op_alu;
        logic       illegal_op;
        logic       mem_timeout;
    } ctl_t;

    typedef struct {
        logic        rst;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic        zero;
        logic        ready;
        logic [3:0]  st;
        ctl_t        ctl;
        int unsigned ret;
    } vec_t;

    localparam logic [5:0] OpR   = 6'b000000;
    localparam logic [5:0] OpJ   = 6'b000010;
    localparam logic [5:0] OpJal = 6'b000011;
    localparam logic [5:0] OpBeq = 6'b000100;
    localparam logic [5:0] OpBne = 6'b000101;
    localparam logic [5:0] OpAdi = 6'b001000;
    localparam logic [5:0] OpLw  = 6'b100011;
    localparam logic [5:0] OpSw  = 6'b101011;
    localparam logic [5:0] OpBad = 6'b111111;
    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnJr  = 6'b001000;

    localparam ctl_t CNone   = '0;
    localparam ctl_t CFetch  = '{mem_read: 1'b1, alu_src_b: 2'b01, default: '0};
    localparam ctl_t CFetchR = '{mem_read: 1'b1, ir_write: 1'b1, pc_write: 1'b1,
                                 alu_src_b: 2'b01, default: '0};
    localparam ctl_t CTo     = '{mem_timeout: 1'b1, default: '0};
    localparam ctl_t CDec    = '{alu_src_b: 2'b11, default: '0};
    localparam ctl_t CIll    = '{illegal_op: 1'b1, default: '0};
    localparam ctl_t CAddr   = '{alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
    localparam ctl_t CRd     = '{mem_read: 1'b1, i_or_d: 1'b1, default: '0};
    localparam ctl_t CMemWb  = '{reg_write: 1'b1, mem_to_reg: 1'b1, default: '0};
    localparam ctl_t CWr     = '{mem_write: 1'b1, i_or_d: 1'b1, default: '0};
    localparam ctl_t CRExec  = '{alu_src_a: 1'b1, op_alu: 4'b0010, default: '0};
    localparam ctl_t CRWb    = '{reg_write: 1'b1, reg_dst: 1'b1, default: '0};
    localparam ctl_t CIWb    = '{reg_write: 1'b1, default: '0};
    localparam ctl_t CJump   = '{pc_write: 1'b1, pc_source: 2'b10, default: '0};
    localparam ctl_t CBr     = '{alu_src_a: 1'b1, op_alu: 4'b0001, pc_source: 2'b01,
                                 default: '0};
    localparam ctl_t CCond   = '{pc_write_cond: 1'b1, default: '0};
    localparam ctl_t CJr     = '{pc_write: 1'b1, pc_source: 2'b11, default: '0};

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    mips_multicycle_control_if #(.CNT_W(CntW)) bus ();

    mips_multicycle_control #(
        .MEM_TIMEOUT(MemTimeout),
        .CNT_W      (CntW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(logic rst, logic [5:0] op, logic [5:0] fn, logic z, logic rdy,
                                logic [3:0] st, ctl_t c, int unsigned ret);
        vec_t v;
        v.rst = rst; v.opcode = op; v.funct = fn; v.zero = z; v.ready = rdy;
        v.st = st; v.ctl = c; v.ret = ret;
        return v;
    endfunction

    function automatic void add(logic rst, logic [5:0] op, logic [5:0] fn, logic z, logic rdy,
                                logic [3:0] st, ctl_t c, int unsigned ret);
        vecs.push_back(mk(rst, op, fn, z, rdy, st, c, ret));
    endfunction

    task automatic check_out();
        vec_t e;
        ctl_t act;
        e = exp_q.pop_front();
        act = '{mem_read: bus.mem_read, mem_write: bus.mem_write, i_or_d: bus.i_or_d,
                ir_write: bus.ir_write, pc_write: bus.pc_write,
                pc_write_cond: bus.pc_write_cond, reg_write: bus.reg_write,
                reg_dst: bus.reg_dst, mem_to_reg: bus.mem_to_reg, alu_src_a: bus.alu_src_a,
                alu_src_b: bus.alu_src_b, pc_source: bus.pc_source, op_alu: bus.op_alu,
                illegal_op: bus.illegal_op, mem_timeout: bus.mem_timeout};
        checks++;
        if (bus.state !== e.st) begin
            errors++;
            $display("FAIL step %0d state: got %0d, want %0d", step_no, bus.state, e.st);
        end
        checks++;
        if (act !== e.ctl) begin
            errors++;
            $display("FAIL step %0d controls: got %h, want %h", step_no, act, e.ctl);
        end
        checks++;
        if (bus.retired !== CntW'(e.ret)) begin
            errors++;
            $display("FAIL step %0d retired: got %0d, want %0d", step_no, bus.retired, e.ret);
        end
    endtask

    // Drive one cycle's inputs at negedge, record the expectation, compare before the next edge.
    task automatic apply(input vec_t v);
        @(negedge clock);
        reset         = v.rst;
        bus.opcode    = v.opcode;
        bus.funct     = v.funct;
        bus.alu_zero  = v.zero;
        bus.mem_ready = v.ready;
        exp_q.push_back(v);
        #2;
        check_out();
        step_no++;
    endtask

    task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input logic [3:0] st, input ctl_t c,
                        input int unsigned ret);
        apply(mk(rst, op, fn, z, rdy, st, c, ret));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.opcode    = OpLw;
        bus.funct     = '0;
        bus.alu_zero  = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clock);

        // Held reset: FETCH state but every control output forced low.
        add(1, OpLw,  FnAdd, 0, 1, 0, CNone,   0);
        // lw, memory ready immediately
        add(0, OpLw,  FnAdd, 0, 1, 0, CFetchR, 0);
        add(0, OpLw,  FnAdd, 0, 1, 1, CDec,    0);
        add(0, OpLw,  FnAdd, 0, 1, 2, CAddr,   0);
        add(0, OpLw,  FnAdd, 0, 1, 3, CRd,     0);
        add(0, OpLw,  FnAdd, 0, 1, 4, CMemWb,  0);
        // sw, ready arrives on the last allowed wait cycle and still wins
        add(0, OpSw,  FnAdd, 0, 1, 0, CFetchR, 1);
        add(0, OpSw,  FnAdd, 0, 1, 1, CDec,    1);
        add(0, OpSw,  FnAdd, 0, 0, 2, CAddr,   1);
        add(0, OpSw,  FnAdd, 0, 0, 5, CWr,     1);
        add(0, OpSw,  FnAdd, 0, 0, 5, CWr,     1);
        add(0, OpSw,  FnAdd, 0, 0, 5, CWr,     1);
        add(0, OpSw,  FnAdd, 0, 1, 5, CWr,     1);
        // beq taken, bne not taken, both with alu_zero=1
        add(0, OpBeq, FnAdd, 1, 1, 0, CFetchR, 2);
        add(0, OpBeq, FnAdd, 1, 0, 1, CDec,    2);
        add(0, OpBeq, FnAdd, 1, 0, 8, CBr | CCond, 2);
        add(0, OpBne, FnAdd, 1, 1, 0, CFetchR, 3);
        add(0, OpBne, FnAdd, 1, 1, 1, CDec,    3);
        add(0, OpBne, FnAdd, 1, 1, 8, CBr,     3);
        // fetch timeout: four cycles without ready, then refetch
        add(0, OpR,   FnAdd, 0, 0, 0, CFetch,  4);
        add(0, OpR,   FnAdd, 0, 0, 0, CFetch,  4);
        add(0, OpR,   FnAdd, 0, 0, 0, CFetch,  4);
        add(0, OpR,   FnAdd, 0, 0, 0, CFetch | CTo, 4);
        // R-type add
        add(0, OpR,   FnAdd, 0, 1, 0, CFetchR, 4);
        add(0, OpR,   FnAdd, 0, 1, 1, CDec,    4);
        add(0, OpR,   FnAdd, 0, 1, 6, CRExec,  4);
        add(0, OpR,   FnAdd, 0, 1, 7, CRWb,    4);
        // addi
        add(0, OpAdi, FnAdd, 0, 1, 0, CFetchR, 5);
        add(0, OpAdi, FnAdd, 0, 1, 1, CDec,    5);
        add(0, OpAdi, FnAdd, 0, 1, 10, CAddr,  5);
        add(0, OpAdi, FnAdd, 0, 1, 11, CIWb,   5);
        // j
        add(0, OpJ,   FnAdd, 0, 1, 0, CFetchR, 6);
        add(0, OpJ,   FnAdd, 0, 1, 1, CDec,    6);
        add(0, OpJ,   FnAdd, 0, 1, 9, CJump,   6);
        // illegal opcode
        add(0, OpBad, FnAdd, 0, 1, 0, CFetchR, 7);
        add(0, OpBad, FnAdd, 0, 1, 1, CDec | CIll, 7);
        foreach (vecs[i]) apply(vecs[i]);

        // lw whose data read times out
        step(0, OpLw, FnAdd, 0, 1, 0, CFetchR, 7);
        step(0, OpLw, FnAdd, 0, 1, 1, CDec,    7);
        step(0, OpLw, FnAdd, 0, 1, 2, CAddr,   7);
        for (int k = 0; k < 3; k++) step(0, OpLw, FnAdd, 0, 0, 3, CRd, 7);
        step(0, OpLw, FnAdd, 0, 0, 3, CRd | CTo, 7);

        // reset while waiting in MEM_RD aborts the load
        step(0, OpLw, FnAdd, 0, 1, 0, CFetchR, 7);
        step(0, OpLw, FnAdd, 0, 1, 1, CDec,    7);
        step(0, OpLw, FnAdd, 0, 1, 2, CAddr,   7);
        step(0, OpLw, FnAdd, 0, 0, 3, CRd,     7);
        step(1, OpLw, FnAdd, 0, 1, 3, CNone,   7);
        step(0, OpLw, FnAdd, 0, 0, 0, CFetch,  0);

        // jal followed by jr
        step(0, OpJal, FnAdd, 0, 1, 0, CFetchR, 0);
`ifdef MULTICYCLE_JAL_JR_EN
        step(0, OpJal, FnAdd, 0, 1, 1, CDec,    0);
        step(0, OpJal, FnAdd, 0, 1, 9, CJump | CIWb, 0);
        step(0, OpR,   FnJr,  0, 1, 0, CFetchR, 1);
        step(0, OpR,   FnJr,  0, 1, 1, CDec,    1);
        step(0, OpR,   FnJr,  0, 1, 6, CRExec | CJr, 1);
        step(0, OpR,   FnJr,  0, 0, 0, CFetch,  2);
`else
        step(0, OpJal, FnAdd, 0, 1, 1, CDec | CIll, 0);
        step(0, OpR,   FnJr,  0, 1, 0, CFetchR, 0);
        step(0, OpR,   FnJr,  0, 1, 1, CDec,    0);
        step(0, OpR,   FnJr,  0, 1, 6, CRExec,  0);
        step(0, OpR,   FnJr,  0, 1, 7, CRWb,    0);
        step(0, OpR,   FnJr,  0, 0, 0, CFetch,  1);
`endif

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
